// File: rtl/emissions_pkg.sv
// Shared types and default configuration for the emissions alert responder.
// The optional stuck-critical detector is enabled with EMIS_STUCK_DETECT_EN.
package emissions_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARN    = 2'd1,
        CRIT    = 2'd2,
        RECOVER = 2'd3
    } alert_state_t;

    localparam int unsigned PERSIST_DEF     = 4;
    localparam int unsigned BLINK_DIV_DEF   = 25;
    localparam int unsigned DERATE_HOLD_DEF = 16;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned STUCK_LIMIT_DEF = 1000;

endpackage

// File: rtl/emis_persist_filter.sv
// Persistence filter: qualified is high on the PERSIST-th consecutive edge
// (and onwards) at which cond is sampled true.
module emis_persist_filter #(
    parameter int unsigned PERSIST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cond,
    output logic qualified
);

    localparam int unsigned CW = (PERSIST > 1) ? $clog2(PERSIST) : 1;
    localparam logic [CW-1:0] SAT = CW'(PERSIST - 1);

    logic [CW-1:0] cnt;

    // Saturating run-length of cond; any false sample restarts the run
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!cond) begin
            cnt <= '0;
        end else if (cnt != SAT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign qualified = cond && (cnt == SAT);

endmodule

// File: rtl/emissions_alert_responder.sv
// Qualifies warning/critical and drives lamp, chime, derate and event count.
// Optional stuck-critical detector enabled with EMIS_STUCK_DETECT_EN.
module emissions_alert_responder
    import emissions_pkg::*;
#(
    parameter int unsigned PERSIST     = PERSIST_DEF,
    parameter int unsigned BLINK_DIV   = BLINK_DIV_DEF,
    parameter int unsigned DERATE_HOLD = DERATE_HOLD_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned STUCK_LIMIT = STUCK_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             warning,
    input  logic             critical,
    input  logic             ack,
    output logic             lamp,
    output logic             chime,
    output logic             derate_req,
    output logic [1:0]       alert_state,
    output logic [CNT_W-1:0] event_count,
    output logic             event_pulse,
    output logic             sensor_fault
);

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);
    localparam int unsigned HOLD_W  = $clog2(DERATE_HOLD + 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(DERATE_HOLD - 1);

    logic hot_q, any_q, quiet_q, cool_q;

    emis_persist_filter #(.PERSIST(PERSIST)) u_hot (
        .clk(clk), .reset(reset), .cond(critical), .qualified(hot_q)
    );
    emis_persist_filter #(.PERSIST(PERSIST)) u_any (
        .clk(clk), .reset(reset), .cond(warning | critical), .qualified(any_q)
    );
    emis_persist_filter #(.PERSIST(PERSIST)) u_quiet (
        .clk(clk), .reset(reset), .cond(~warning & ~critical), .qualified(quiet_q)
    );
    emis_persist_filter #(.PERSIST(PERSIST)) u_cool (
        .clk(clk), .reset(reset), .cond(~critical), .qualified(cool_q)
    );

    alert_state_t       state, state_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               lamp_nxt, chime_nxt, derate_nxt, crit_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            blink_cnt   <= '0;
            hold_cnt    <= '0;
            lamp        <= 1'b0;
            chime       <= 1'b0;
            derate_req  <= 1'b0;
            event_count <= '0;
            event_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            blink_cnt   <= blink_nxt;
            hold_cnt    <= hold_nxt;
            lamp        <= lamp_nxt;
            chime       <= chime_nxt;
            derate_req  <= derate_nxt;
            event_count <= count_nxt;
            event_pulse <= crit_entry;
        end
    end

    always_comb begin
        state_nxt  = state;
        blink_nxt  = blink_cnt;
        hold_nxt   = hold_cnt;
        lamp_nxt   = lamp;
        chime_nxt  = chime;
        count_nxt  = event_count;
        crit_entry = 1'b0;

        case (state)
            IDLE: begin
                if (hot_q)      state_nxt = CRIT;
                else if (any_q) state_nxt = WARN;
            end
            WARN: begin
                if (hot_q)        state_nxt = CRIT;
                else if (quiet_q) state_nxt = IDLE;
            end
            CRIT: begin
                if (cool_q) begin
                    state_nxt = RECOVER;
                    hold_nxt  = '0;
                end
            end
            RECOVER: begin
                if (hot_q) begin
                    state_nxt = CRIT;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_nxt = warning ? WARN : IDLE;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        crit_entry = (state_nxt == CRIT) && (state != CRIT);

        // Lamp follows the state being entered; CRIT blinks from a fresh phase
        case (state_nxt)
            IDLE:    lamp_nxt = 1'b0;
            WARN:    lamp_nxt = 1'b1;
            RECOVER: lamp_nxt = 1'b1;
            CRIT: begin
                if (crit_entry) begin
                    lamp_nxt  = 1'b1;
                    blink_nxt = '0;
                end else if (blink_cnt == BLINK_MAX) begin
                    lamp_nxt  = ~lamp;
                    blink_nxt = '0;
                end else begin
                    blink_nxt = blink_cnt + BLINK_W'(1);
                end
            end
            default: lamp_nxt = 1'b0;
        endcase

        derate_nxt = (state_nxt == CRIT) || (state_nxt == RECOVER);

        // A new critical event outranks a simultaneous acknowledge
        if (crit_entry)  chime_nxt = 1'b1;
        else if (ack)    chime_nxt = 1'b0;

        if (crit_entry && (event_count != {CNT_W{1'b1}})) begin
            count_nxt = event_count + CNT_W'(1);
        end
    end

    assign alert_state = state;

`ifdef EMIS_STUCK_DETECT_EN
    localparam int unsigned STUCK_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX  = STUCK_W'(STUCK_LIMIT);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_LIMIT - 1);

    logic [STUCK_W-1:0] stuck_cnt;

    // Run length of critical=1; fault asserts on the edge the run reaches the limit
    always_ff @(posedge clk) begin
        if (reset || !critical) begin
            stuck_cnt    <= '0;
            sensor_fault <= 1'b0;
        end else begin
            if (stuck_cnt != STUCK_MAX) stuck_cnt <= stuck_cnt + STUCK_W'(1);
            if (stuck_cnt >= STUCK_LAST) sensor_fault <= 1'b1;
        end
    end
`else
    logic unused_stuck_limit;
    assign unused_stuck_limit = |32'(STUCK_LIMIT);
    assign sensor_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_emissions_alert_responder.sv
// Directed bench for emissions_alert_responder; a CNT_W=2 twin shares stimulus.
module tb_emissions_alert_responder;

    logic clk = 1'b0;
    logic reset, warning, critical, ack;

    logic       lamp, chime, derate_req, event_pulse, sensor_fault;
    logic [1:0] alert_state;
    logic [7:0] event_count;

    logic       s_lamp, s_chime, s_derate_req, s_event_pulse, s_sensor_fault;
    logic [1:0] s_alert_state;
    logic [1:0] s_event_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    emissions_alert_responder #(
        .PERSIST(4), .BLINK_DIV(5), .DERATE_HOLD(8), .CNT_W(8), .STUCK_LIMIT(20)
    ) u_dut (
        .clk(clk), .reset(reset), .warning(warning), .critical(critical), .ack(ack),
        .lamp(lamp), .chime(chime), .derate_req(derate_req), .alert_state(alert_state),
        .event_count(event_count), .event_pulse(event_pulse), .sensor_fault(sensor_fault)
    );

    emissions_alert_responder #(
        .PERSIST(4), .BLINK_DIV(5), .DERATE_HOLD(8), .CNT_W(2), .STUCK_LIMIT(20)
    ) u_small (
        .clk(clk), .reset(reset), .warning(warning), .critical(critical), .ack(ack),
        .lamp(s_lamp), .chime(s_chime), .derate_req(s_derate_req), .alert_state(s_alert_state),
        .event_count(s_event_count), .event_pulse(s_event_pulse), .sensor_fault(s_sensor_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] fault_exp;
`ifdef EMIS_STUCK_DETECT_EN
        fault_exp = 32'd1;
`else
        fault_exp = 32'd0;
`endif
        reset = 1'b1; warning = 1'b0; critical = 1'b0; ack = 1'b0;
        tick(); tick();
        check("rst_state",  32'(alert_state), 0);
        check("rst_lamp",   32'(lamp), 0);
        check("rst_chime",  32'(chime), 0);
        check("rst_derate", 32'(derate_req), 0);
        check("rst_count",  32'(event_count), 0);
        check("rst_pulse",  32'(event_pulse), 0);
        check("rst_fault",  32'(sensor_fault), 0);
        reset = 1'b0;

        // 3-cycle warning glitch must be filtered
        warning = 1'b1;
        repeat (3) begin
            tick();
            check("t1_state", 32'(alert_state), 0);
            check("t1_lamp",  32'(lamp), 0);
        end
        warning = 1'b0;
        tick();
        check("t1_after", 32'(alert_state), 0);

        // 4-cycle warning qualifies on the 4th edge
        warning = 1'b1;
        repeat (3) begin tick(); check("t2_pre", 32'(alert_state), 0); end
        tick();
        check("t2_warn_state", 32'(alert_state), 1);
        check("t2_warn_lamp",  32'(lamp), 1);
        warning = 1'b0;
        repeat (3) begin tick(); check("t2_hold", 32'(alert_state), 1); end
        tick();
        check("t2_idle_state", 32'(alert_state), 0);
        check("t2_idle_lamp",  32'(lamp), 0);

        // CRIT entry and blinking
        critical = 1'b1;
        repeat (3) tick();
        check("t3_pre", 32'(alert_state), 0);
        tick();
        check("t3_state",  32'(alert_state), 2);
        check("t3_pulse",  32'(event_pulse), 1);
        check("t3_count",  32'(event_count), 1);
        check("t3_chime",  32'(chime), 1);
        check("t3_derate", 32'(derate_req), 1);
        check("t3_lamp0",  32'(lamp), 1);
        tick();
        check("t3_pulse_off", 32'(event_pulse), 0);
        repeat (3) tick();
        check("t3_lamp4", 32'(lamp), 1);
        tick();
        check("t3_lamp5", 32'(lamp), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t3_ack_chime", 32'(chime), 0);
        check("t3_ack_lamp",  32'(lamp), 0);
        repeat (3) tick();
        check("t3_lamp9", 32'(lamp), 0);
        tick();
        check("t3_lamp10",  32'(lamp), 1);
        check("t3_state10", 32'(alert_state), 2);

        // RECOVER with critical re-asserted during hold cycle 3
        critical = 1'b0;
        repeat (4) tick();
        check("t4_rec_state",  32'(alert_state), 3);
        check("t4_rec_derate", 32'(derate_req), 1);
        check("t4_rec_lamp",   32'(lamp), 1);
        tick(); tick();
        critical = 1'b1;
        repeat (3) begin tick(); check("t4_rec_hold", 32'(alert_state), 3); end
        tick();
        check("t4_re_state", 32'(alert_state), 2);
        check("t4_re_count", 32'(event_count), 2);
        check("t4_re_chime", 32'(chime), 1);
        check("t4_re_pulse", 32'(event_pulse), 1);

        // RECOVER runs to expiry with warning low
        critical = 1'b0;
        repeat (4) tick();
        check("t4b_rec_state", 32'(alert_state), 3);
        repeat (7) begin
            tick();
            check("t4b_hold_state",  32'(alert_state), 3);
            check("t4b_hold_derate", 32'(derate_req), 1);
        end
        tick();
        check("t4b_exp_state",  32'(alert_state), 0);
        check("t4b_exp_derate", 32'(derate_req), 0);
        check("t4b_exp_lamp",   32'(lamp), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t4b_ack_chime", 32'(chime), 0);
        check("t4b_small_cnt", 32'(s_event_count), 2);

        // Counter saturation on the CNT_W=2 twin
        critical = 1'b1;
        repeat (4) tick();
        check("t5_e3_state", 32'(alert_state), 2);
        check("t5_e3_count", 32'(event_count), 3);
        check("t5_e3_small", 32'(s_event_count), 3);
        critical = 1'b0;
        repeat (4) tick();
        check("t5_e4_rec", 32'(alert_state), 3);
        critical = 1'b1;
        repeat (4) tick();
        check("t5_e4_state", 32'(alert_state), 2);
        check("t5_e4_count", 32'(event_count), 4);
        check("t5_e4_small", 32'(s_event_count), 3);
        critical = 1'b0;
        repeat (4) tick();
        critical = 1'b1;
        repeat (3) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t5_e5_pulse",   32'(event_pulse), 1);
        check("t5_e5_chime",   32'(chime), 1);
        check("t5_e5_s_chime", 32'(s_chime), 1);
        check("t5_e5_count",   32'(event_count), 5);
        check("t5_e5_small",   32'(s_event_count), 3);

        // Mid-CRIT reset, then stuck-critical detection
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_state",  32'(alert_state), 0);
        check("t6_lamp",   32'(lamp), 0);
        check("t6_chime",  32'(chime), 0);
        check("t6_derate", 32'(derate_req), 0);
        check("t6_pulse",  32'(event_pulse), 0);
        check("t6_count",  32'(event_count), 0);
        check("t6_small",  32'(s_event_count), 0);
        check("t6_fault",  32'(sensor_fault), 0);
        repeat (19) tick();
        check("t6_fault19", 32'(sensor_fault), 0);
        tick();
        check("t6_fault20",   32'(sensor_fault), fault_exp);
        check("t6_state20",   32'(alert_state), 2);
        check("t6_count20",   32'(event_count), 1);
        critical = 1'b0;
        tick();
        check("t6_fault_clr", 32'(sensor_fault), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/emissions_alert_responder.md
Name: emissions_alert_responder

Overview:
- Consumer end of the emissions monitor's `warning`/`critical` outputs.
- Qualifies both flags with a persistence filter, then drives the dashboard lamp (steady or blinking), the chime with driver acknowledge, and the engine derate request with a hold-off.
- Counts critical events for diagnostics.
- Sits between the emissions FSM and the body/powertrain controllers.

Parameters:
- PERSIST, 4: consecutive sampled cycles a condition must hold before a state transition (≥1).
- BLINK_DIV, 25: cycles per lamp half-period in CRIT (≥1).
- DERATE_HOLD, 16: cycles derate stays asserted after critical clears (≥1).
- CNT_W, 8: event counter width.
- STUCK_LIMIT, 1000: used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- warning  in  1  warning flag from the emissions FSM.
- critical  in  1  critical flag from the emissions FSM.
- ack  in  1  driver acknowledge, 1-cycle pulse.
- lamp  out  1  dashboard emissions lamp.
- chime  out  1  audible alert, high until acknowledged.
- derate_req  out  1  engine power-derate request.
- alert_state  out  2  current state encoding.
- event_count  out  CNT_W  number of CRIT entries, saturating.
- event_pulse  out  1  1-cycle pulse on each CRIT entry.
- sensor_fault  out  1  stuck-critical flag; tied 0 without the optional feature.

Behaviour:
- Reset: synchronous, active-high. On the next clk edge: state IDLE; lamp, chime, derate_req, event_pulse, sensor_fault = 0; event_count = 0; all counters = 0. Applies mid-operation; derate drops on that edge.
- States and encoding: IDLE=0, WARN=1, CRIT=2, RECOVER=3. All outputs are registered.
- Input conditions:
  - hot = critical.
  - any = warning | critical.
  - quiet = ~warning & ~critical.
  - cool = ~critical.
  - warning and critical both high is treated as critical.
- Persistence filtering:
  - Each condition has a saturating consecutive counter, cleared on any cycle the condition is false.
  - A condition is "qualified" on the PERSIST-th consecutive rising edge at which it is sampled true.
  - The transition takes effect on that same edge.
  - PERSIST=1 means the next edge.
- IDLE:
  - hot qualified → CRIT.
  - Otherwise any qualified → WARN.
  - lamp=0, derate_req=0.
- WARN:
  - hot qualified → CRIT.
  - quiet qualified → IDLE.
  - lamp=1 steady.
- CRIT entry (from any state):
  - event_pulse=1 for one cycle.
  - event_count+1, saturating at all-ones.
  - chime=1, derate_req=1.
  - lamp=1 and blink counter reset.
- CRIT:
  - lamp toggles every BLINK_DIV cycles.
  - cool qualified → RECOVER.
- RECOVER:
  - lamp=1 steady; derate_req stays 1.
  - Hold counter counts DERATE_HOLD cycles.
  - hot qualified before expiry → CRIT; this is a new event.
  - On expiry → WARN if warning is high that cycle, else IDLE. derate_req=0 on that edge.
- Chime:
  - ack high clears chime on the next edge.
  - Chime re-arms only on a CRIT entry.
  - ack in the same cycle as a CRIT entry: entry wins, chime=1.
  - ack has no effect when chime=0.
- Persistence counters are not reset by state changes; only the condition going false or reset clears them.

Optional Feature:
- Macro: EMIS_STUCK_DETECT_EN.
- Defined:
  - A counter tracks consecutive cycles with critical=1, saturating.
  - sensor_fault=1 once the count reaches STUCK_LIMIT.
  - sensor_fault clears on the first cycle critical=0, or on reset.
  - Setting sensor_fault does not change the state machine.
- Undefined: sensor_fault is driven constant 0 and no counter logic exists.

Decomposition:
- Shared package emissions_pkg holds:
  - alert_state_t enum (IDLE/WARN/CRIT/RECOVER, 2-bit).
  - Default parameter constants.
- Sub-module emis_persist_filter:
  - Parameter PERSIST; ports clk, reset, cond, qualified.
  - Instantiated four times (hot, any, quiet, cool).
- Blink and hold counters stay inline.

Test Plan:
Common settings: PERSIST=4, BLINK_DIV=5, DERATE_HOLD=8, CNT_W=8.
1. Release reset; hold warning=1 for 3 cycles, then 0 → alert_state stays 0, lamp=0 throughout.
2. Hold warning=1 for 4 cycles → alert_state=1 and lamp=1 on the 4th edge; then warning=0 for 4 cycles → alert_state=0, lamp=0.
3. Hold critical=1 for 4 cycles → alert_state=2, event_pulse high exactly one cycle, event_count=1, chime=1, derate_req=1, lamp toggling every 5 cycles; pulse ack → chime=0 next edge while lamp keeps blinking.
4. From CRIT, drive critical=0 for 4 cycles → alert_state=3, derate_req=1 for 8 cycles, then alert_state=0 and derate_req=0. Repeat, but re-assert critical 4 cycles during hold cycle 3 → alert_state=2, event_count=2, chime=1.
5. With CNT_W=2, cause 5 CRIT entries → event_count=3 after the 3rd entry and stays 3; ack coincident with the 5th entry leaves chime=1.
6. Assert reset for one cycle while in CRIT → all outputs and event_count are 0 on the next edge. With EMIS_STUCK_DETECT_EN and STUCK_LIMIT=20, hold critical for 20 cycles → sensor_fault=1; drop critical → sensor_fault=0 next edge.
